// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes, EX/MEM FSM encodings.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned QTR_W  = 2;
    localparam int unsigned REG_W  = 5;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_NOTA = 4'd5;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd9;
    localparam logic [OP_W-1:0] ALU_PASSB = 4'd10;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    // Writeback control carried alongside a memory access
    typedef struct packed {
        logic [QTR_W-1:0] quarter;
        logic             write;
        logic [REG_W-1:0] write_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bundle of ID/EX inputs, RAM handshake and writeback outputs for the EX/MEM stage.
interface ex_mem_stage_if;
    import cpu_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] readData0;
    logic [DATA_W-1:0] readData1;
    logic [OP_W-1:0]   ALUOp;
    logic              ReadMem;
    logic              WriteMem;
    logic [DATA_W-1:0] DataIn;
    logic [QTR_W-1:0]  quarter;
    logic              write;
    logic [REG_W-1:0]  writeReg;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [QTR_W-1:0]  wb_quarter;
    logic              wb_write;
    logic [REG_W-1:0]  wb_writeReg;
    logic              mem_err;

    // Pipeline/RAM environment side
    modport master (
        output in_valid, readData0, readData1, ALUOp, ReadMem, WriteMem, DataIn,
               quarter, write, writeReg, mem_rdata, mem_ack,
        input  stall, mem_req, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_data, wb_quarter, wb_write, wb_writeReg, mem_err
    );

    // EX/MEM stage side
    modport slave (
        input  in_valid, readData0, readData1, ALUOp, ReadMem, WriteMem, DataIn,
               quarter, write, writeReg, mem_rdata, mem_ack,
        output stall, mem_req, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_data, wb_quarter, wb_write, wb_writeReg, mem_err
    );

endinterface

// File: rtl/alu16.sv
// 16-bit combinational ALU; shifts use only the low four bits of b.
module alu16
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOTA:  y = ~a;
            ALU_SLL:   y = a << b[3:0];
            ALU_SRL:   y = a >> b[3:0];
            ALU_SRA:   y = DATA_W'($signed(a) >>> b[3:0]);
            ALU_SLT:   y = {15'd0, ($signed(a) < $signed(b))};
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute/memory pipeline stage: ALU, single outstanding RAM access with timeout,
// and registered writeback.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_mem_stage_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [DATA_W-1:0] alu_y;

    logic [0:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    wb_ctrl_t          ctrl_q,      ctrl_d;
    logic              is_load_q,   is_load_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [DATA_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_err_q,   mem_err_d;
    logic              wb_valid_q,  wb_valid_d;
    logic [DATA_W-1:0] wb_data_q,   wb_data_d;
    logic [QTR_W-1:0]  wb_qtr_q,    wb_qtr_d;
    logic              wb_write_q,  wb_write_d;
    logic [REG_W-1:0]  wb_reg_q,    wb_reg_d;

    alu16 u_alu (
        .a  (bus.readData0),
        .b  (bus.readData1),
        .op (bus.ALUOp),
        .y  (alu_y)
    );

    // Upstream freezes while an access is outstanding; released in the ack cycle
    assign bus.stall = (state_q == ST_MEM_WAIT) && !bus.mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            is_load_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_err_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_qtr_q    <= '0;
            wb_write_q  <= 1'b0;
            wb_reg_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            is_load_q   <= is_load_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_err_q   <= mem_err_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_qtr_q    <= wb_qtr_d;
            wb_write_q  <= wb_write_d;
            wb_reg_q    <= wb_reg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        is_load_d   = is_load_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_err_d   = mem_err_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_qtr_d    = wb_qtr_q;
        wb_write_d  = 1'b0;
        wb_reg_d    = wb_reg_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.ReadMem || bus.WriteMem) begin
                        // Load+store together behaves as a store with no register writeback
                        state_d          = ST_MEM_WAIT;
                        cnt_d            = '0;
                        mem_req_d        = 1'b1;
                        mem_we_d         = bus.WriteMem;
                        mem_addr_d       = alu_y;
                        mem_wdata_d      = bus.DataIn;
                        is_load_d        = bus.ReadMem && !bus.WriteMem;
                        ctrl_d.quarter   = bus.quarter;
                        ctrl_d.write     = bus.write && !(bus.ReadMem && bus.WriteMem);
                        ctrl_d.write_reg = bus.writeReg;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_y;
                        wb_qtr_d   = bus.quarter;
                        wb_write_d = bus.write;
                        wb_reg_d   = bus.writeReg;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = is_load_q ? bus.mem_rdata : mem_addr_q;
                    wb_qtr_d   = ctrl_q.quarter;
                    wb_write_d = ctrl_q.write;
                    wb_reg_d   = ctrl_q.write_reg;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon the access: retire the instruction without writing a register
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_err_d  = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    wb_qtr_d   = ctrl_q.quarter;
                    wb_write_d = 1'b0;
                    wb_reg_d   = ctrl_q.write_reg;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_err     = mem_err_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_quarter  = wb_qtr_q;
    assign bus.wb_write    = wb_write_q;
    assign bus.wb_writeReg = wb_reg_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ex_mem_stage_if bus ();

    ex_mem_stage #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic rm, input logic wm,
                         input logic [15:0] din, input logic [1:0] q, input logic w,
                         input logic [4:0] r);
        bus.in_valid  = v;
        bus.ALUOp     = op;
        bus.readData0 = a;
        bus.readData1 = b;
        bus.ReadMem   = rm;
        bus.WriteMem  = wm;
        bus.DataIn    = din;
        bus.quarter   = q;
        bus.write     = w;
        bus.writeReg  = r;
    endtask

    task automatic alu_case(input string tag, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] exp);
        drive(1'b1, op, a, b, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 5'd1);
        tick();
        check({tag, "_valid"}, 16'(bus.wb_valid), 16'h1);
        check(tag, bus.wb_data, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},   16'(bus.stall),       16'h0);
        check({tag, "_req"},     16'(bus.mem_req),     16'h0);
        check({tag, "_we"},      16'(bus.mem_we),      16'h0);
        check({tag, "_addr"},    bus.mem_addr,         16'h0);
        check({tag, "_wdata"},   bus.mem_wdata,        16'h0);
        check({tag, "_wbv"},     16'(bus.wb_valid),    16'h0);
        check({tag, "_wbdata"},  bus.wb_data,          16'h0);
        check({tag, "_wbq"},     16'(bus.wb_quarter),  16'h0);
        check({tag, "_wbw"},     16'(bus.wb_write),    16'h0);
        check({tag, "_wbreg"},   16'(bus.wb_writeReg), 16'h0);
        check({tag, "_err"},     16'(bus.mem_err),     16'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, ALU_ADD, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0;
        repeat (3) tick();
        check_all_zero("reset");

        // First instruction presented as reset releases; signed overflow wraps
        rst_n = 1'b1;
        drive(1'b1, ALU_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0, 2'd2, 1'b1, 5'd7);
        tick();
        check("add_valid", 16'(bus.wb_valid),    16'h1);
        check("add_data",  bus.wb_data,          16'h8000);
        check("add_qtr",   16'(bus.wb_quarter),  16'h2);
        check("add_write", 16'(bus.wb_write),    16'h1);
        check("add_reg",   16'(bus.wb_writeReg), 16'h7);
        check("add_stall", 16'(bus.stall),       16'h0);
        check("add_req",   16'(bus.mem_req),     16'h0);
        bus.in_valid = 1'b0;
        tick();
        check("idle_valid", 16'(bus.wb_valid), 16'h0);
        check("idle_write", 16'(bus.wb_write), 16'h0);

        alu_case("sub",   ALU_SUB,   16'h0005, 16'h0007, 16'hFFFE);
        alu_case("and",   ALU_AND,   16'hF0F0, 16'h3C3C, 16'h3030);
        alu_case("or",    ALU_OR,    16'hF0F0, 16'h3C3C, 16'hFCFC);
        alu_case("xor",   ALU_XOR,   16'hF0F0, 16'h3C3C, 16'hCCCC);
        alu_case("nota",  ALU_NOTA,  16'h00FF, 16'h1234, 16'hFF00);
        alu_case("sll",   ALU_SLL,   16'h0001, 16'h0014, 16'h0010);
        alu_case("srl",   ALU_SRL,   16'h8000, 16'h0003, 16'h1000);
        alu_case("sra",   ALU_SRA,   16'h8000, 16'h0003, 16'hF000);
        alu_case("slt_t", ALU_SLT,   16'hFFFF, 16'h0001, 16'h0001);
        alu_case("slt_f", ALU_SLT,   16'h0001, 16'hFFFF, 16'h0000);
        alu_case("passb", ALU_PASSB, 16'h1111, 16'h1234, 16'h1234);
        alu_case("op12",  4'd12,     16'hFFFF, 16'hFFFF, 16'h0000);

        // Load with three stalled cycles before ack; in_valid must be ignored meanwhile
        drive(1'b1, ALU_ADD, 16'h0010, 16'h0004, 1'b1, 1'b0, 16'h5555, 2'd1, 1'b1, 5'd3);
        tick();
        drive(1'b1, ALU_ADD, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 5'd9);
        check("ld_req",   16'(bus.mem_req),  16'h1);
        check("ld_we",    16'(bus.mem_we),   16'h0);
        check("ld_addr",  bus.mem_addr,      16'h0014);
        check("ld_wbv",   16'(bus.wb_valid), 16'h0);
        check("ld_stall1", 16'(bus.stall),   16'h1);
        tick();
        check("ld_stall2", 16'(bus.stall),   16'h1);
        check("ld_wbv2",   16'(bus.wb_valid), 16'h0);
        tick();
        check("ld_stall3", 16'(bus.stall),   16'h1);
        check("ld_addr3",  bus.mem_addr,     16'h0014);
        check("ld_req3",   16'(bus.mem_req), 16'h1);
        tick();
        bus.in_valid  = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        #1;
        check("ld_stall_ack", 16'(bus.stall), 16'h0);
        tick();
        bus.mem_ack = 1'b0;
        check("ld_wbv",   16'(bus.wb_valid),    16'h1);
        check("ld_data",  bus.wb_data,          16'hBEEF);
        check("ld_write", 16'(bus.wb_write),    16'h1);
        check("ld_reg",   16'(bus.wb_writeReg), 16'h3);
        check("ld_qtr",   16'(bus.wb_quarter),  16'h1);
        check("ld_reqlo", 16'(bus.mem_req),     16'h0);
        tick();
        check("ld_pulse", 16'(bus.wb_valid), 16'h0);

        // Both load and store requested: store wins, no register writeback
        drive(1'b1, ALU_ADD, 16'h0100, 16'h0020, 1'b1, 1'b1, 16'h1234, 2'd0, 1'b1, 5'd4);
        tick();
        bus.in_valid  = 1'b0;
        check("st_we",    16'(bus.mem_we),  16'h1);
        check("st_wdata", bus.mem_wdata,    16'h1234);
        check("st_addr",  bus.mem_addr,     16'h0120);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_ack = 1'b0;
        check("st_wbv",   16'(bus.wb_valid), 16'h1);
        check("st_write", 16'(bus.wb_write), 16'h0);
        check("st_data",  bus.wb_data,       16'h0120);

        // Stray ack while idle changes nothing
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        tick();
        bus.mem_ack = 1'b0;
        check("stray_wbv", 16'(bus.wb_valid), 16'h0);
        check("stray_req", 16'(bus.mem_req),  16'h0);

        // Load never acknowledged: times out on the fifteenth waiting cycle
        drive(1'b1, ALU_ADD, 16'h0002, 16'h0003, 1'b1, 1'b0, 16'h0, 2'd3, 1'b1, 5'd6);
        tick();
        bus.in_valid = 1'b0;
        check("to_req0", 16'(bus.mem_req), 16'h1);
        repeat (14) tick();
        check("to_req14", 16'(bus.mem_req), 16'h1);
        check("to_err14", 16'(bus.mem_err), 16'h0);
        check("to_wbv14", 16'(bus.wb_valid), 16'h0);
        tick();
        check("to_req",   16'(bus.mem_req),  16'h0);
        check("to_err",   16'(bus.mem_err),  16'h1);
        check("to_wbv",   16'(bus.wb_valid), 16'h1);
        check("to_write", 16'(bus.wb_write), 16'h0);
        check("to_stall", 16'(bus.stall),    16'h0);
        drive(1'b1, ALU_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 5'd2);
        tick();
        bus.in_valid = 1'b0;
        check("post_wbv",  16'(bus.wb_valid), 16'h1);
        check("post_data", bus.wb_data,       16'h0002);
        check("post_err",  16'(bus.mem_err),  16'h1);

        // Reset in the middle of a wait clears everything at once
        drive(1'b1, ALU_ADD, 16'h0040, 16'h0002, 1'b1, 1'b0, 16'h7777, 2'd1, 1'b1, 5'd5);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("mid_stall", 16'(bus.stall), 16'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hCAFE;
        tick();
        check("rst_ack_wbv", 16'(bus.wb_valid), 16'h0);
        rst_n = 1'b1;
        drive(1'b1, ALU_SUB, 16'h0010, 16'h0001, 1'b0, 1'b0, 16'h0, 2'd2, 1'b1, 5'd8);
        tick();
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        check("rel_wbv",  16'(bus.wb_valid),    16'h1);
        check("rel_data", bus.wb_data,          16'h000F);
        check("rel_reg",  16'(bus.wb_writeReg), 16'h8);
        check("rel_req",  16'(bus.mem_req),     16'h0);
        check("rel_err",  16'(bus.mem_err),     16'h0);
        tick();
        check("rel_pulse", 16'(bus.wb_valid), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
